character_motion: RTL and testbench

//  Per-frame position/velocity controller for one player sprite; drives x/y/width/height into the map collision

---
 rtl/motion_pkg.sv | 52 +++++
 rtl/frame_tick_sync.sv | 29 ++
 rtl/character_motion.sv | 219 +++++++++++++++++++++
 tb/tb_character_motion.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and constants for the character motion controller.
// Optional feature macro: MOTION_COYOTE_EN (ledge grace-jump window).
package motion_pkg;

  typedef enum logic [1:0] {
    MS_GROUND = 2'd0,
    MS_RISE   = 2'd1,
    MS_FALL   = 2'd2
  } mstate_t;

  typedef logic signed [5:0] vel_t;

  localparam logic [6:0] CHAR_W = 7'd16;
  localparam logic [6:0] CHAR_H = 7'd24;

  localparam logic [9:0] X_START   = 10'd40;
  localparam logic [9:0] Y_START   = 10'd420;
  localparam logic [9:0] X_MIN     = 10'd0;
  localparam logic [9:0] X_MAX     = 10'd639;
  localparam logic [9:0] Y_MIN     = 10'd0;
  localparam logic [9:0] Y_MAX     = 10'd479;
  localparam logic [9:0] WALK_STEP = 10'd2;

  localparam vel_t JUMP_VEL  = 6'sd8;
  localparam vel_t VMAX_FALL = 6'sd6;

  // Gravity adds 1 to y_vel once every GRAV_DIV ticks; the counter wraps at GRAV_LAST.
  localparam int         GRAV_DIV  = 3;
  localparam logic [1:0] GRAV_LAST = 2'(GRAV_DIV - 1);

  localparam logic [2:0] COYOTE_FRAMES = 3'd4;

  // Zero-extend a screen coordinate into the signed working width.
  function automatic logic signed [10:0] widen(input logic [9:0] p);
    return $signed({1'b0, p});
  endfunction

  // Position plus a signed velocity, in the signed working width.
  function automatic logic signed [10:0] add_vel(input logic [9:0] p, input vel_t v);
    return $signed({1'b0, p}) + $signed({{5{v[5]}}, v});
  endfunction

  // Clamp a signed working-width coordinate into [lo, hi].
  function automatic logic [9:0] clamp_pos(input logic signed [10:0] v,
                                           input logic [9:0] lo,
                                           input logic [9:0] hi);
    if (v < widen(lo)) return lo;
    else if (v > widen(hi)) return hi;
    else return v[9:0];
  endfunction

endpackage

// File: rtl/frame_tick_sync.sv
// Brings the asynchronous vsync-rate frame_clk level into the Clk domain
// (two synchroniser flops) and emits a one-cycle tick on its rising edge.
module frame_tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic frame_clk,
  output logic tick
);

  logic meta;
  logic s1;
  logic s2;

  // Synchroniser chain plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      s1   <= 1'b0;
      s2   <= 1'b0;
    end else begin
      meta <= frame_clk;
      s1   <= meta;
      s2   <= s1;
    end
  end

  assign tick = s1 & ~s2;

endmodule

// File: rtl/character_motion.sv
// Per-frame position/velocity controller for one player sprite.
// Updates once per frame tick; consumes map collision flags for the current
// x/y. Optional feature macro: MOTION_COYOTE_EN enables a short grace window
// after walking off a ledge during which a jump is still accepted.
// state and y_vel are exported for observation.
module character_motion
  import motion_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       respawn,
  input  logic       col_up,
  input  logic       col_down,
  input  logic       col_left,
  input  logic       col_right,
  input  logic       col_left_end,
  input  logic       col_right_end,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic [6:0] width,
  output logic [6:0] height,
  output logic       on_ground,
  output logic       facing_left,
  output mstate_t    state,
  output vel_t       y_vel
);

  localparam vel_t JUMP_INIT = -JUMP_VEL;

  logic tick;

  frame_tick_sync u_sync (
    .clk       (Clk),
    .rst       (Reset),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  logic [1:0] grav_cnt;

  logic [9:0]         x_n;
  logic [9:0]         y_n;
  vel_t               vel_n;
  logic [1:0]         grav_n;
  mstate_t            st_n;
  logic               face_n;
  logic signed [10:0] x_calc;
  logic signed [10:0] y_calc;
  logic               grav_wrap;
  logic [1:0]         grav_step;
  vel_t               vel_grav;
  vel_t               vel_fall;
  logic               start_jump;

`ifdef MOTION_COYOTE_EN
  logic [2:0] coyote_cnt;
  logic [2:0] coy_n;
`endif

  // Next-frame motion: horizontal walk/push-out, vertical state machine, clamps.
  always_comb begin
    x_n    = x;
    y_n    = y;
    vel_n  = y_vel;
    grav_n = grav_cnt;
    st_n   = state;
    face_n = facing_left;
    x_calc = widen(x);
    y_calc = widen(y);

    grav_wrap = (grav_cnt == GRAV_LAST);
    grav_step = grav_wrap ? 2'd0 : grav_cnt + 2'd1;
    vel_grav  = grav_wrap ? y_vel + 6'sd1 : y_vel;
    vel_fall  = (vel_grav > VMAX_FALL) ? VMAX_FALL : vel_grav;

    start_jump = (state == MS_GROUND) && key_jump && !col_up;
`ifdef MOTION_COYOTE_EN
    coy_n = coyote_cnt;
    if ((state == MS_FALL) && key_jump && !col_up && (coyote_cnt != 3'd0))
      start_jump = 1'b1;
`endif

    // Horizontal: exactly one direction key moves; a wall flag pushes back out by 1.
    if (key_left ^ key_right) begin
      if (key_left) begin
        face_n = 1'b1;
        x_calc = col_left ? widen(x) + 11'sd1 : widen(x) - widen(WALK_STEP);
      end else begin
        face_n = 1'b0;
        x_calc = col_right ? widen(x) - 11'sd1 : widen(x) + widen(WALK_STEP);
      end
    end
    x_n = clamp_pos(x_calc, X_MIN, X_MAX);

    // Vertical: the new velocity is applied to y in the same tick.
    if (start_jump) begin
      st_n   = MS_RISE;
      vel_n  = JUMP_INIT;
      grav_n = 2'd0;
      y_calc = add_vel(y, JUMP_INIT);
`ifdef MOTION_COYOTE_EN
      coy_n  = 3'd0;
`endif
    end else begin
      case (state)
        MS_GROUND: begin
          grav_n = 2'd0;
          if (!col_down && !col_left_end && !col_right_end) begin
            st_n  = MS_FALL;
            vel_n = 6'sd1;
`ifdef MOTION_COYOTE_EN
            coy_n = COYOTE_FRAMES;
`endif
          end else begin
            vel_n = 6'sd0;
          end
        end
        MS_RISE: begin
          if (col_up) begin
            st_n   = MS_FALL;
            vel_n  = 6'sd0;
            grav_n = 2'd0;
            y_calc = widen(y) + 11'sd1;
          end else begin
            vel_n  = vel_grav;
            grav_n = grav_step;
            y_calc = add_vel(y, vel_grav);
            if (vel_grav >= 6'sd0) st_n = MS_FALL;
          end
        end
        MS_FALL: begin
          if (col_down) begin
            st_n   = MS_GROUND;
            vel_n  = 6'sd0;
            grav_n = 2'd0;
`ifdef MOTION_COYOTE_EN
            coy_n  = 3'd0;
`endif
          end else begin
            vel_n  = vel_fall;
            grav_n = grav_step;
            y_calc = add_vel(y, vel_fall);
`ifdef MOTION_COYOTE_EN
            coy_n  = (coyote_cnt != 3'd0) ? coyote_cnt - 3'd1 : 3'd0;
`endif
          end
        end
        default: begin
          st_n   = MS_GROUND;
          vel_n  = 6'sd0;
          grav_n = 2'd0;
        end
      endcase
    end

    // Screen floor acts as ground; screen ceiling ends a rise.
    if (y_calc >= widen(Y_MAX)) begin
      y_n    = Y_MAX;
      st_n   = MS_GROUND;
      vel_n  = 6'sd0;
      grav_n = 2'd0;
`ifdef MOTION_COYOTE_EN
      coy_n  = 3'd0;
`endif
    end else if (y_calc <= widen(Y_MIN)) begin
      y_n = Y_MIN;
      if (st_n == MS_RISE) begin
        st_n  = MS_FALL;
        vel_n = 6'sd0;
      end
    end else begin
      y_n = y_calc[9:0];
    end
  end

  // Motion registers: reset/respawn restore the start pose; otherwise load on tick.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      x           <= X_START;
      y           <= Y_START;
      y_vel       <= 6'sd0;
      grav_cnt    <= 2'd0;
      state       <= MS_GROUND;
      facing_left <= 1'b0;
`ifdef MOTION_COYOTE_EN
      coyote_cnt  <= 3'd0;
`endif
    end else if (respawn) begin
      x           <= X_START;
      y           <= Y_START;
      y_vel       <= 6'sd0;
      grav_cnt    <= 2'd0;
      state       <= MS_GROUND;
      facing_left <= 1'b0;
`ifdef MOTION_COYOTE_EN
      coyote_cnt  <= 3'd0;
`endif
    end else if (tick) begin
      x           <= x_n;
      y           <= y_n;
      y_vel       <= vel_n;
      grav_cnt    <= grav_n;
      state       <= st_n;
      facing_left <= face_n;
`ifdef MOTION_COYOTE_EN
      coyote_cnt  <= coy_n;
`endif
    end
  end

  assign on_ground = (state == MS_GROUND);
  assign width     = CHAR_W;
  assign height    = CHAR_H;

endmodule

// File: tb/tb_character_motion.sv
// Directed bench for character_motion: a table of per-tick vectors followed by
// hand-written sequences for tick latency, respawn, clamps, gravity saturation,
// ledge grace (MOTION_COYOTE_EN aware) and asynchronous reset.
module tb_character_motion;
  import motion_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0;
  logic       respawn = 1'b0;
  logic       col_up = 1'b0, col_down = 1'b0, col_left = 1'b0, col_right = 1'b0;
  logic       col_left_end = 1'b0, col_right_end = 1'b0;
  logic [9:0] x, y;
  logic [6:0] width, height;
  logic       on_ground, facing_left;
  mstate_t    state;
  vel_t       y_vel;

  character_motion dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .key_left      (key_left),
    .key_right     (key_right),
    .key_jump      (key_jump),
    .respawn       (respawn),
    .col_up        (col_up),
    .col_down      (col_down),
    .col_left      (col_left),
    .col_right     (col_right),
    .col_left_end  (col_left_end),
    .col_right_end (col_right_end),
    .x             (x),
    .y             (y),
    .width         (width),
    .height        (height),
    .on_ground     (on_ground),
    .facing_left   (facing_left),
    .state         (state),
    .y_vel         (y_vel)
  );

  // ---------------- clock ----------------
  always #5 Clk = ~Clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] KN = 3'b000, KL = 3'b100, KR = 3'b010, KJ = 3'b001;
  localparam logic [5:0] CN = 6'b000000, CU = 6'b100000, CD = 6'b010000;
  localparam logic [5:0] CL = 6'b001000, CR = 6'b000100, CLE = 6'b000010;

  typedef struct {
    logic [2:0] keys;   // {left, right, jump}
    logic [5:0] cols;   // {up, down, left, right, left_end, right_end}
    int         ex;
    int         ey;
    int         ev;
    mstate_t    est;
    logic       ef;
  } vec_t;

  vec_t vecs[$];

  int rise_y[24] = '{404, 396, 389, 382, 375, 369, 363, 357, 352, 347, 342, 338,
                     334, 330, 327, 324, 321, 319, 317, 315, 314, 313, 312, 312};
  int rise_v[24] = '{-8, -8, -7, -7, -7, -6, -6, -6, -5, -5, -5, -4,
                     -4, -4, -3, -3, -3, -2, -2, -2, -1, -1, -1, 0};

  task automatic add_vec(input logic [2:0] k, input logic [5:0] c, input int ex,
                         input int ey, input int ev, input mstate_t est, input logic ef);
    vec_t v;
    v.keys = k; v.cols = c; v.ex = ex; v.ey = ey; v.ev = ev; v.est = est; v.ef = ef;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int ey, input int ev,
                           input mstate_t est, input logic ef);
    chk({tag, " x"}, int'(x), ex);
    chk({tag, " y"}, int'(y), ey);
    chk({tag, " y_vel"}, int'(y_vel), ev);
    chk({tag, " state"}, int'(state), int'(est));
    chk({tag, " on_ground"}, int'(on_ground), (est == MS_GROUND) ? 1 : 0);
    chk({tag, " facing_left"}, int'(facing_left), int'(ef));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [2:0] k, input logic [5:0] c);
    {key_left, key_right, key_jump} = k;
    {col_up, col_down, col_left, col_right, col_left_end, col_right_end} = c;
  endtask

  // One frame: rising frame_clk, held high, then low long enough to re-arm.
  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic do_respawn();
    @(negedge Clk);
    respawn = 1'b1;
    @(negedge Clk);
    respawn = 1'b0;
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    // Vector table: a continuous scenario starting from reset.
    for (int i = 0; i < 5; i++) add_vec(KN, CD, 40, 420, 0, MS_GROUND, 1'b0);
    for (int i = 0; i < 10; i++) add_vec(KR, CD, 42 + 2 * i, 420, 0, MS_GROUND, 1'b0);
    add_vec(KR, CD | CR, 59, 420, 0, MS_GROUND, 1'b0);
    add_vec(KJ, CD, 59, 412, -8, MS_RISE, 1'b0);
    for (int k = 0; k < 24; k++)
      add_vec(KN, CD, 59, rise_y[k], rise_v[k], (k == 23) ? MS_FALL : MS_RISE, 1'b0);
    add_vec(KN, CD, 59, 312, 0, MS_GROUND, 1'b0);
    add_vec(KJ, CD, 59, 304, -8, MS_RISE, 1'b0);
    add_vec(KN, CU | CD, 59, 305, 0, MS_FALL, 1'b0);
    add_vec(KN, CD, 59, 305, 0, MS_GROUND, 1'b0);
    add_vec(KL | KR, CD, 59, 305, 0, MS_GROUND, 1'b0);
    add_vec(KL, CD, 57, 305, 0, MS_GROUND, 1'b1);
    add_vec(KL, CD | CL, 58, 305, 0, MS_GROUND, 1'b1);
    add_vec(KN, CLE, 58, 305, 0, MS_GROUND, 1'b1);
    add_vec(KJ, CU | CD, 58, 305, 0, MS_GROUND, 1'b1);

    // Reset state, checked while reset is still asserted.
    repeat (3) @(negedge Clk);
    check_all("reset", 40, 420, 0, MS_GROUND, 1'b0);
    chk("width", int'(width), 16);
    chk("height", int'(height), 24);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    for (int i = 0; i < vecs.size(); i++) begin
      set_in(vecs[i].keys, vecs[i].cols);
      do_tick();
      check_all($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].ev,
                vecs[i].est, vecs[i].ef);
    end

    // Respawn takes effect on the next Clk edge and clears facing_left.
    set_in(KN, CD);
    do_respawn();
    check_all("respawn", 40, 420, 0, MS_GROUND, 1'b0);

    // Latency: x moves on the third Clk edge after frame_clk rises, exactly once.
    set_in(KR, CD);
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    chk("lat edge2 x", int'(x), 40);
    @(negedge Clk);
    chk("lat edge3 x", int'(x), 42);
    repeat (6) @(negedge Clk);
    chk("lat held x", int'(x), 42);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    // Respawn wins over a tick landing on the same edge.
    do_respawn();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (2) @(negedge Clk);
    respawn = 1'b1;
    @(negedge Clk);
    respawn = 1'b0;
    chk("respawn prio x", int'(x), 40);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);

    // Push-out to 41, then walk left into the X_MIN clamp.
    set_in(KL, CD | CL);
    do_tick();
    check_all("pushout", 41, 420, 0, MS_GROUND, 1'b1);
    set_in(KL, CD);
    ticks(20);
    chk("walk left x", int'(x), 1);
    do_tick();
    chk("xmin clamp x", int'(x), 0);
    do_tick();
    chk("xmin hold x", int'(x), 0);

    // Walk off a ledge, fall one tick, respawn mid-fall.
    set_in(KN, CN);
    do_tick();
    check_all("ledge", 0, 420, 1, MS_FALL, 1'b1);
    do_tick();
    check_all("fall1", 0, 421, 1, MS_FALL, 1'b1);
    do_respawn();
    check_all("respawn fall", 40, 420, 0, MS_GROUND, 1'b0);

    // Fall from start height to the screen floor.
    ticks(17);
    check_all("pre floor", 40, 476, 6, MS_FALL, 1'b0);
    do_tick();
    check_all("floor", 40, 479, 0, MS_GROUND, 1'b0);

    // Long fall after a full jump: fall speed saturates at 6.
    do_respawn();
    set_in(KJ, CN);
    do_tick();
    set_in(KN, CN);
    ticks(24);
    check_all("apex", 40, 312, 0, MS_FALL, 1'b0);
    ticks(21);
    check_all("vmax", 40, 381, 6, MS_FALL, 1'b0);

    // Jump pressed two ticks after walking off a ledge.
    do_respawn();
    set_in(KN, CN);
    ticks(2);
    chk("coyote pre y", int'(y), 421);
    set_in(KJ, CN);
    do_tick();
`ifdef MOTION_COYOTE_EN
    check_all("coyote jump", 40, 413, -8, MS_RISE, 1'b0);
`else
    check_all("no coyote", 40, 422, 1, MS_FALL, 1'b0);
`endif

    // Jump pressed after the grace window has run out is ignored in any build.
    do_respawn();
    set_in(KN, CN);
    ticks(5);
    chk("late pre y", int'(y), 426);
    set_in(KJ, CN);
    do_tick();
    check_all("late jump", 40, 428, 2, MS_FALL, 1'b0);

    // Asynchronous reset in the middle of a jump.
    do_respawn();
    set_in(KR | KJ, CD);
    do_tick();
    check_all("jump r", 42, 412, -8, MS_RISE, 1'b0);
    set_in(KR, CD);
    do_tick();
    check_all("rise r", 44, 404, -8, MS_RISE, 1'b0);
    set_in(KN, CD);
    #3;
    Reset = 1'b1;
    #1;
    check_all("async reset", 40, 420, 0, MS_GROUND, 1'b0);
    @(negedge Clk);
    Reset = 1'b0;
    do_tick();
    check_all("after reset", 40, 420, 0, MS_GROUND, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
